// File: rtl/kf8237_transfer_timing_pkg.sv
// KF8237_Common_Package: shared transfer-state, type and mode encodings for the KF8237 DMA controller.
// Revision 1.0
`default_nettype none

package KF8237_Common_Package;

  typedef enum logic [2:0] {
    ST_SI      = 3'd0,
    ST_S0      = 3'd1,
    ST_S1      = 3'd2,
    ST_S2      = 3'd3,
    ST_S3      = 3'd4,
    ST_SW      = 3'd5,
    ST_S4      = 3'd6,
    ST_CASCADE = 3'd7
  } xfer_state_t;

  localparam logic [1:0] TYPE_VERIFY = 2'b00;
  localparam logic [1:0] TYPE_WRITE  = 2'b01;
  localparam logic [1:0] TYPE_READ   = 2'b10;

  localparam logic [1:0] MODE_DEMAND  = 2'b00;
  localparam logic [1:0] MODE_SINGLE  = 2'b01;
  localparam logic [1:0] MODE_BLOCK   = 2'b10;
  localparam logic [1:0] MODE_CASCADE = 2'b11;

  function automatic logic [1:0] bit2num(input logic [3:0] one_hot);
    logic [1:0] num;
    num = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (one_hot[i]) num = 2'(i);
    end
    return num;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kf8237_transfer_timing_strobe_decoder.sv
// kf8237_strobe_decoder: maps bus-cycle state and transfer type onto the active-low read/write strobes.
// Revision 1.0
`default_nettype none

module kf8237_strobe_decoder
  import KF8237_Common_Package::*;
(
  input  xfer_state_t state_i,
  input  logic [1:0]  transfer_type_i,
  output logic        memory_read_n_o,
  output logic        memory_write_n_o,
  output logic        io_read_n_o,
  output logic        io_write_n_o
);

  logic read_phase;
  logic write_phase;

  // Read strobe opens in S2 and stays through S3/SW; write strobe only in S3/SW.
  always_comb begin
    read_phase  = (state_i == ST_S2) || (state_i == ST_S3) || (state_i == ST_SW);
    write_phase = (state_i == ST_S3) || (state_i == ST_SW);

    memory_read_n_o  = ~(read_phase  && (transfer_type_i == TYPE_READ));
    io_read_n_o      = ~(read_phase  && (transfer_type_i == TYPE_WRITE));
    memory_write_n_o = ~(write_phase && (transfer_type_i == TYPE_WRITE));
    io_write_n_o     = ~(write_phase && (transfer_type_i == TYPE_READ));
  end

endmodule

`default_nettype wire

// File: rtl/kf8237_transfer_timing.sv
// kf8237_transfer_timing: 8237 bus-cycle sequencer (SI..S4, SW, cascade) and per-word register-bank strobes.
// Revision 1.0
`default_nettype none

module kf8237_transfer_timing
  import KF8237_Common_Package::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_clock_posedge,
  input  logic       cpu_clock_negedge,
  input  logic       controller_disable,
  input  logic       request_valid,
  input  logic [3:0] request_select,
  input  logic [1:0] transfer_type,
  input  logic [1:0] transfer_mode,
  input  logic       autoinitialize,
  input  logic       hold_acknowledge,
  input  logic       ready,
  input  logic       end_of_process_in,
  input  logic       underflow,
  input  logic       update_high_address,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge,
  output logic       address_enable,
  output logic       address_strobe,
  output logic       memory_read_n,
  output logic       memory_write_n,
  output logic       io_read_n,
  output logic       io_write_n,
  output logic       end_of_process_out,
  output logic [3:0] transfer_register_select,
  output logic       next_word,
  output logic       initialize_current_register,
  output logic [3:0] terminal_count,
  input  logic       clear_terminal_count
);

  xfer_state_t state_q;
  logic [3:0]  sel_q;
  logic [1:0]  type_q;
  logic [1:0]  mode_q;
  logic        autoinit_q;
  logic        hrq_q, aen_q, adstb_q, next_word_q, init_q, eop_out_q;
  logic [3:0]  dack_q;
  logic        eop_pend_q, abort_q;
  logic [3:0]  tc_q, tc_d, tc_set;
  logic        word_active, in_transfer, tc_now, end_word;

  assign word_active = (state_q == ST_S1) || (state_q == ST_S2) ||
                       (state_q == ST_S3) || (state_q == ST_SW);
  assign in_transfer = word_active || (state_q == ST_S4);
  assign tc_now      = underflow | eop_pend_q | end_of_process_in;
  assign end_word    = abort_q | ~hold_acknowledge | controller_disable |
                       (mode_q == MODE_SINGLE) |
                       ((mode_q == MODE_DEMAND) & ~request_valid);
  assign tc_set      = (cpu_clock_posedge && (state_q == ST_S4) && tc_now) ? sel_q : 4'b0000;
  assign tc_d        = (tc_q & ~{4{clear_terminal_count}}) | tc_set;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SI;
      sel_q       <= 4'b0000;
      type_q      <= TYPE_VERIFY;
      mode_q      <= MODE_DEMAND;
      autoinit_q  <= 1'b0;
      hrq_q       <= 1'b0;
      dack_q      <= 4'b0000;
      aen_q       <= 1'b0;
      adstb_q     <= 1'b0;
      next_word_q <= 1'b0;
      init_q      <= 1'b0;
      eop_out_q   <= 1'b0;
    end else if (cpu_clock_posedge) begin
      adstb_q     <= 1'b0;
      next_word_q <= 1'b0;
      init_q      <= 1'b0;
      eop_out_q   <= 1'b0;
      case (state_q)
        ST_SI: begin
          if (request_valid && !controller_disable) begin
            state_q <= ST_S0;
            hrq_q   <= 1'b1;
          end
        end
        ST_S0: begin
          if (!request_valid || controller_disable) begin
            state_q <= ST_SI;
            hrq_q   <= 1'b0;
          end else if (hold_acknowledge) begin
            sel_q      <= request_select;
            dack_q     <= request_select;
            type_q     <= transfer_type;
            mode_q     <= transfer_mode;
            autoinit_q <= autoinitialize;
            if (transfer_mode == MODE_CASCADE) begin
              state_q <= ST_CASCADE;
            end else begin
              state_q <= ST_S1;
              aen_q   <= 1'b1;
              adstb_q <= 1'b1;
            end
          end
        end
        ST_CASCADE: begin
          if (!request_valid) begin
            state_q <= ST_SI;
            hrq_q   <= 1'b0;
            dack_q  <= 4'b0000;
          end
        end
        ST_S1: state_q <= ST_S2;
        ST_S2: state_q <= ST_S3;
        ST_S3, ST_SW: begin
          if (ready) begin
            state_q     <= ST_S4;
            next_word_q <= 1'b1;
            eop_out_q   <= underflow;
          end else begin
            state_q <= ST_SW;
          end
        end
        ST_S4: begin
          if (tc_now || end_word) begin
            state_q <= ST_SI;
            hrq_q   <= 1'b0;
            dack_q  <= 4'b0000;
            aen_q   <= 1'b0;
            init_q  <= tc_now & autoinit_q;
          end else if (update_high_address) begin
            state_q <= ST_S1;
            adstb_q <= 1'b1;
          end else begin
            state_q <= ST_S2;
          end
        end
        default: state_q <= ST_SI;
      endcase
    end
  end

  // EOP and abort requests are remembered so the word in flight always completes first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eop_pend_q <= 1'b0;
      abort_q    <= 1'b0;
    end else if ((state_q == ST_SI) || (state_q == ST_S0)) begin
      eop_pend_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      if (cpu_clock_negedge && word_active && end_of_process_in) eop_pend_q <= 1'b1;
      if (in_transfer && (!hold_acknowledge || controller_disable)) abort_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tc_q <= 4'b0000;
    else       tc_q <= tc_d;
  end

  kf8237_strobe_decoder u_strobe_decoder (
    .state_i          (state_q),
    .transfer_type_i  (type_q),
    .memory_read_n_o  (memory_read_n),
    .memory_write_n_o (memory_write_n),
    .io_read_n_o      (io_read_n),
    .io_write_n_o     (io_write_n)
  );

  assign hold_request                = hrq_q;
  assign dma_acknowledge             = dack_q;
  assign address_enable              = aen_q;
  assign address_strobe              = adstb_q;
  assign end_of_process_out          = eop_out_q;
  assign transfer_register_select    = sel_q;
  assign next_word                   = next_word_q;
  assign initialize_current_register = init_q;
  assign terminal_count              = tc_q;

endmodule

`default_nettype wire

// File: tb/tb_kf8237_transfer_timing.sv
// tb_kf8237_transfer_timing: vector table, directed corner sequences and randomized transfers against a transfer-level model.
// Revision 1.0
`default_nettype none

module tb_kf8237_transfer_timing;

  logic clock, reset, cpu_clock_posedge, cpu_clock_negedge, controller_disable;
  logic request_valid, autoinitialize, hold_acknowledge, ready, end_of_process_in;
  logic underflow, update_high_address, clear_terminal_count;
  logic [3:0] request_select;
  logic [1:0] transfer_type, transfer_mode;
  logic hold_request, address_enable, address_strobe, memory_read_n, memory_write_n;
  logic io_read_n, io_write_n, end_of_process_out, next_word, initialize_current_register;
  logic [3:0] dma_acknowledge, transfer_register_select, terminal_count;

  kf8237_transfer_timing dut (
    .clock(clock), .reset(reset),
    .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
    .controller_disable(controller_disable), .request_valid(request_valid),
    .request_select(request_select), .transfer_type(transfer_type),
    .transfer_mode(transfer_mode), .autoinitialize(autoinitialize),
    .hold_acknowledge(hold_acknowledge), .ready(ready),
    .end_of_process_in(end_of_process_in), .underflow(underflow),
    .update_high_address(update_high_address), .hold_request(hold_request),
    .dma_acknowledge(dma_acknowledge), .address_enable(address_enable),
    .address_strobe(address_strobe), .memory_read_n(memory_read_n),
    .memory_write_n(memory_write_n), .io_read_n(io_read_n), .io_write_n(io_write_n),
    .end_of_process_out(end_of_process_out),
    .transfer_register_select(transfer_register_select), .next_word(next_word),
    .initialize_current_register(initialize_current_register),
    .terminal_count(terminal_count), .clear_terminal_count(clear_terminal_count)
  );

  // One record per DMA clock: inputs held for that clock, outputs expected just after its rising edge.
  typedef struct {
    logic req, hlda, rdy, uf, uha, eopi, clr;
    logic hrq; logic [3:0] dack; logic aen, adstb;
    logic [3:0] strb;
    logic eopo, nw, init;
    logic [3:0] tc, trs;
  } vec_t;

  vec_t       tbl [7];
  vec_t       vq[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] m_tc     = 4'h0;
  logic [3:0] m_trs    = 4'h0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // DMA clock = system clock / 4; enables change on the falling system edge.
  initial begin
    int ph;
    ph = 0;
    cpu_clock_posedge = 1'b0;
    cpu_clock_negedge = 1'b0;
    forever begin
      @(negedge clock);
      ph = (ph + 1) % 4;
      cpu_clock_posedge = (ph == 0);
      cpu_clock_negedge = (ph == 2);
    end
  end

  function automatic logic [21:0] act_pack();
    return {hold_request, dma_acknowledge, address_enable, address_strobe,
            memory_read_n, memory_write_n, io_read_n, io_write_n,
            end_of_process_out, next_word, initialize_current_register,
            terminal_count, transfer_register_select};
  endfunction

  function automatic logic [21:0] want_pack(input vec_t v);
    return {v.hrq, v.dack, v.aen, v.adstb, v.strb, v.eopo, v.nw, v.init, v.tc, v.trs};
  endfunction

  // Strobes as {MEMR#, MEMW#, IOR#, IOW#}; ph 0 = none, 1 = read window, 2 = read+write window.
  function automatic logic [3:0] strb_of(input int ty, input int ph);
    logic [3:0] s;
    s = 4'hF;
    if (ph >= 1) begin
      if (ty == 2) s[3] = 1'b0;
      if (ty == 1) s[1] = 1'b0;
    end
    if (ph == 2) begin
      if (ty == 2) s[0] = 1'b0;
      if (ty == 1) s[2] = 1'b0;
    end
    return s;
  endfunction

  task automatic check(input string nm, input logic [21:0] act, input logic [21:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, want);
  endtask

  task automatic dma_step();
    do @(posedge clock); while (cpu_clock_posedge !== 1'b1);
    #1;
  endtask

  task automatic apply(input vec_t v, input string nm);
    request_valid        = v.req;
    hold_acknowledge     = v.hlda;
    ready                = v.rdy;
    underflow            = v.uf;
    update_high_address  = v.uha;
    end_of_process_in    = v.eopi;
    clear_terminal_count = v.clr;
    dma_step();
    check(nm, act_pack(), want_pack(v));
  endtask

  task automatic add(input logic req, hlda, rdy, uf, uha, eopi, clr,
                     input logic hrq, input logic [3:0] dack, input logic aen, adstb,
                     input logic [3:0] strb, input logic eopo, nw, init);
    vec_t v;
    v = '{req, hlda, rdy, uf, uha, eopi, clr, hrq, dack, aen, adstb, strb, eopo, nw, init, m_tc, m_trs};
    vq.push_back(v);
  endtask

  task automatic run_queue(input string tag);
    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("%s[%0d]", tag, i));
    vq.delete();
  endtask

  task automatic set_cfg(input int ch, input int ty, input int md, input logic ai);
    request_select = 4'(1 << ch);
    transfer_type  = 2'(ty);
    transfer_mode  = 2'(md);
    autoinitialize = ai;
  endtask

  // Transfer-level model: words run S1?,S2,S3,SW*,S4; the last word ends in TC when it underflows.
  task automatic gen_xfer(input int ch, input int ty, input int md, input logic ai,
                          input int n, input int drop, input logic ufl,
                          input logic clr_tc, input logic uha_en);
    logic [3:0] sel;
    int         words;
    logic       in_s1, uf, uha;
    sel   = 4'(1 << ch);
    words = (drop != 0) ? drop : n;
    set_cfg(ch, ty, md, ai);
    add(1, 0, 0, 0, 0, 0, 0,  1, 4'h0, 0, 0, 4'hF, 0, 0, 0);
    m_trs = sel;
    add(1, 1, 0, 0, 0, 0, 0,  1, sel, 1, 1, 4'hF, 0, 0, 0);
    in_s1 = 1'b1;
    for (int w = 0; w < words; w++) begin
      uf = (w == words - 1) ? ufl : 1'b0;
      if (in_s1) add(1, 1, 1'($urandom_range(0, 1)), uf, 0, 0, 0,  1, sel, 1, 0, strb_of(ty, 1), 0, 0, 0);
      add(1, 1, 1'($urandom_range(0, 1)), uf, 0, 0, 0,  1, sel, 1, 0, strb_of(ty, 2), 0, 0, 0);
      repeat ($urandom_range(0, 3)) add(1, 1, 0, uf, 0, 0, 0,  1, sel, 1, 0, strb_of(ty, 2), 0, 0, 0);
      add(1, 1, 1, uf, 0, 0, 0,  1, sel, 1, 0, 4'hF, uf, 1, 0);
      if (w == words - 1) begin
        if (clr_tc) m_tc = 4'h0;
        if (uf) m_tc = m_tc | sel;
        add(0, 1, 0, uf, 0, 0, clr_tc,  0, 4'h0, 0, 0, 4'hF, 0, 0, uf & ai);
        add(0, 0, 0, 0, 0, 0, 0,  0, 4'h0, 0, 0, 4'hF, 0, 0, 0);
      end else begin
        uha = uha_en ? 1'($urandom_range(0, 1)) : 1'b0;
        add(1, 1, 0, 0, uha, 0, 0,  1, sel, 1, uha, uha ? 4'hF : strb_of(ty, 1), 0, 0, 0);
        in_s1 = uha;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    controller_disable = 1'b0; request_valid = 1'b0; hold_acknowledge = 1'b0;
    ready = 1'b0; end_of_process_in = 1'b0; underflow = 1'b0;
    update_high_address = 1'b0; clear_terminal_count = 1'b0;
    set_cfg(0, 0, 0, 1'b0);

    // Single read, ch1, count wraps on its only word.
    tbl[0] = '{1,0,0,0,0,0,0, 1,4'h0,0,0,4'hF,0,0,0,4'h0,4'h0};
    tbl[1] = '{1,1,0,0,0,0,0, 1,4'h2,1,1,4'hF,0,0,0,4'h0,4'h2};
    tbl[2] = '{1,1,0,0,0,0,0, 1,4'h2,1,0,4'h7,0,0,0,4'h0,4'h2};
    tbl[3] = '{1,1,1,1,0,0,0, 1,4'h2,1,0,4'h6,0,0,0,4'h0,4'h2};
    tbl[4] = '{1,1,1,1,0,0,0, 1,4'h2,1,0,4'hF,1,1,0,4'h0,4'h2};
    tbl[5] = '{0,1,0,1,0,0,0, 0,4'h0,0,0,4'hF,0,0,0,4'h2,4'h2};
    tbl[6] = '{0,0,0,0,0,0,0, 0,4'h0,0,0,4'hF,0,0,0,4'h2,4'h2};

    repeat (6) @(posedge clock);
    #1;
    check("reset_state", act_pack(), {1'b0, 4'h0, 2'b00, 4'hF, 3'b000, 4'h0, 4'h0});
    @(negedge clock);
    reset = 1'b0;
    dma_step();
    check("idle_after_reset", act_pack(), {1'b0, 4'h0, 2'b00, 4'hF, 3'b000, 4'h0, 4'h0});

    set_cfg(1, 2, 1, 1'b0);
    for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("single_read[%0d]", i));
    m_tc = 4'h2; m_trs = 4'h2;

    // EOP raised during S2 of a block: the word completes, then TC with autoinit.
    set_cfg(1, 2, 2, 1'b1);
    add(1, 0, 0, 0, 0, 0, 0,  1, 4'h0, 0, 0, 4'hF, 0, 0, 0);
    m_trs = 4'h2;
    add(1, 1, 0, 0, 0, 0, 0,  1, 4'h2, 1, 1, 4'hF, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,  1, 4'h2, 1, 0, strb_of(2, 1), 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0,  1, 4'h2, 1, 0, strb_of(2, 2), 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0,  1, 4'h2, 1, 0, 4'hF, 0, 1, 0);
    m_tc = m_tc | 4'h2;
    add(1, 1, 0, 0, 0, 0, 0,  0, 4'h0, 0, 0, 4'hF, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,  0, 4'h0, 0, 0, 4'hF, 0, 0, 0);
    run_queue("eop_in");

    // HLDA drops in S2 of a block write: the word finishes, no TC.
    set_cfg(0, 1, 2, 1'b0);
    add(1, 0, 0, 0, 0, 0, 0,  1, 4'h0, 0, 0, 4'hF, 0, 0, 0);
    m_trs = 4'h1;
    add(1, 1, 0, 0, 0, 0, 0,  1, 4'h1, 1, 1, 4'hF, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,  1, 4'h1, 1, 0, strb_of(1, 1), 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  1, 4'h1, 1, 0, strb_of(1, 2), 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0,  1, 4'h1, 1, 0, 4'hF, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0,  0, 4'h0, 0, 0, 4'hF, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 4'h0, 0, 0, 4'hF, 0, 0, 0);
    run_queue("hlda_drop");

    // Cascade on ch3: DACK only, no address or strobes, until the request goes away.
    set_cfg(3, 0, 3, 1'b0);
    add(1, 0, 0, 0, 0, 0, 0,  1, 4'h0, 0, 0, 4'hF, 0, 0, 0);
    m_trs = 4'h8;
    repeat (3) add(1, 1, 0, 0, 0, 0, 0,  1, 4'h8, 0, 0, 4'hF, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,  0, 4'h0, 0, 0, 4'hF, 0, 0, 0);
    run_queue("cascade");

    gen_xfer(0, 1, 2, 1'b0, 3, 0, 1'b1, 1'b0, 1'b0);
    run_queue("block_write");
    gen_xfer(1, 2, 0, 1'b0, 5, 2, 1'b0, 1'b0, 1'b1);
    run_queue("demand_drop");
    gen_xfer(2, 2, 2, 1'b1, 1, 0, 1'b1, 1'b1, 1'b0);
    run_queue("autoinit_clr");

    // Asynchronous reset landing in S3.
    set_cfg(0, 2, 2, 1'b0);
    add(1, 0, 0, 0, 0, 0, 0,  1, 4'h0, 0, 0, 4'hF, 0, 0, 0);
    m_trs = 4'h1;
    add(1, 1, 0, 0, 0, 0, 0,  1, 4'h1, 1, 1, 4'hF, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,  1, 4'h1, 1, 0, strb_of(2, 1), 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,  1, 4'h1, 1, 0, strb_of(2, 2), 0, 0, 0);
    run_queue("pre_reset");
    #2 reset = 1'b1;
    #1 check("async_reset_s3", act_pack(), {1'b0, 4'h0, 2'b00, 4'hF, 3'b000, 4'h0, 4'h0});
    request_valid = 1'b0; hold_acknowledge = 1'b0; ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    m_tc = 4'h0; m_trs = 4'h0;
    dma_step();
    check("idle_after_async_reset", act_pack(), {1'b0, 4'h0, 2'b00, 4'hF, 3'b000, 4'h0, 4'h0});

    for (int t = 0; t < 30; t++) begin
      int ch, ty, md, n, drop;
      logic ufl;
      ch   = $urandom_range(0, 3);
      ty   = $urandom_range(0, 2);
      md   = $urandom_range(0, 2);
      n    = (md == 1) ? 1 : $urandom_range(1, 4);
      drop = ((md == 0) && ($urandom_range(0, 1) == 1)) ? $urandom_range(1, n) : 0;
      ufl  = (md == 1) ? 1'($urandom_range(0, 1)) : (drop != 0) ? 1'b0 : 1'b1;
      gen_xfer(ch, ty, md, 1'($urandom_range(0, 1)), n, drop, ufl,
               ($urandom_range(0, 3) == 0), 1'b1);
      run_queue($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
